// File: rtl/piso_word_feeder.sv
// ============================================================================
//  Module      : piso_word_feeder
//  Description : Buffers band-energy words in a small FIFO and presents one
//                word every WIDTH clocks with a one-cycle load strobe for the
//                downstream PISO serializer. Marks frame starts, flags
//                underruns.
//                Optional build macro: PISO_FEEDER_REPEAT_EN (underrun slots
//                re-emit the last popped word instead of zero).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_word_feeder #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int BANDS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     enable,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     load,
  output logic                     frame_start,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int c_AW    = $clog2(DEPTH);
  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_IDX_W = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam logic [c_AW:0]      c_FULL_LVL = (c_AW+1)'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_SLOT_END = c_CNT_W'(WIDTH - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_END  = c_IDX_W'(BANDS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_slot_cnt;
  logic [c_CNT_W-1:0]   w_slot_cnt_nxt;
  logic [c_IDX_W-1:0]   r_word_idx;
  logic                 w_issue;
  logic                 w_idx_clr;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [c_AW:0]        r_wr_ptr;
  logic [c_AW:0]        r_rd_ptr;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [WIDTH-1:0]     w_head;
  logic [WIDTH-1:0]     w_fill;

  // FIFO status derived purely from the pointer difference
  assign fifo_level = r_wr_ptr - r_rd_ptr;
  assign in_ready   = (fifo_level != c_FULL_LVL);
  assign w_empty    = (fifo_level == '0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = w_issue && !w_empty;
  assign w_head     = r_mem[r_rd_ptr[c_AW-1:0]];

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= in_data;
    end
  end

  // FIFO pointers, wrapping naturally through the extra MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

`ifdef PISO_FEEDER_REPEAT_EN
  logic [WIDTH-1:0] r_last;

  // Remember the last word actually popped so an underrun slot can repeat it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (w_pop) begin
      r_last <= w_head;
    end
  end

  assign w_fill = r_last;
`else
  assign w_fill = '0;
`endif

  // Sequencer state, slot counter and frame word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_slot_cnt <= '0;
      r_word_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot_cnt <= w_slot_cnt_nxt;
      if (w_issue) begin
        r_word_idx <= (r_word_idx == c_IDX_END) ? '0 : r_word_idx + 1'b1;
      end else if (w_idx_clr) begin
        r_word_idx <= '0;
      end
    end
  end

  // Slot timing: a slot is issued on entry to RUN and on every counter wrap;
  // enable is only consulted at slot boundaries
  always_comb begin
    w_state_nxt    = r_state;
    w_slot_cnt_nxt = r_slot_cnt;
    w_issue        = 1'b0;
    w_idx_clr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_slot_cnt_nxt = '0;
        if (enable) begin
          w_state_nxt = S_RUN;
          w_issue     = 1'b1;
        end
      end
      S_RUN: begin
        if (r_slot_cnt == c_SLOT_END) begin
          w_slot_cnt_nxt = '0;
          if (enable) begin
            w_issue = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_idx_clr   = 1'b1;
          end
        end else begin
          w_slot_cnt_nxt = r_slot_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_slot_cnt_nxt = '0;
      end
    endcase
  end

  // Registered PISO-facing outputs; parallel_out holds between slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load         <= 1'b0;
      frame_start  <= 1'b0;
      parallel_out <= '0;
      underrun     <= 1'b0;
    end else begin
      load        <= w_issue;
      frame_start <= w_issue && (r_word_idx == '0);
      if (w_issue) begin
        parallel_out <= w_empty ? w_fill : w_head;
        if (w_empty) underrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_word_feeder.sv
// ============================================================================
//  Module      : tb_piso_word_feeder
//  Description : Self-checking bench for piso_word_feeder with a queue-based
//                reference model of slot timing, FIFO and frame counting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_word_feeder;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int BANDS = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic               enable;
  logic [WIDTH-1:0]   parallel_out;
  logic               load;
  logic               frame_start;
  logic               underrun;
  logic [$clog2(DEPTH):0] fifo_level;

  piso_word_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANDS(BANDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .enable       (enable),
    .parallel_out (parallel_out),
    .load         (load),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue of buffered words, cycles since the last slot,
  // position inside the frame, and the expected registered outputs
  logic [WIDTH-1:0] q[$];
  bit               m_run;
  int               m_since;
  int               m_widx;
  logic [WIDTH-1:0] m_po;
  logic [WIDTH-1:0] m_last;
  bit               m_load;
  bit               m_fs;
  bit               m_ur;
  bit               m_acc;

  // Producer state
  logic [WIDTH-1:0] next_word;
  bit               rnd_data;
  int               words_sent;
  int               feed_limit;
  int               vld_pct;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 0; m_since = 0; m_widx = 0;
    m_po = '0; m_last = '0;
    m_load = 0; m_fs = 0; m_ur = 0; m_acc = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven
  task automatic model_edge();
    bit issue;
    issue = 0;
    m_acc = in_valid && (q.size() < DEPTH);
    if (!m_run) begin
      if (enable) begin
        issue = 1; m_run = 1; m_since = 0;
      end
    end else begin
      m_since++;
      if (m_since == WIDTH) begin
        m_since = 0;
        if (enable) issue = 1;
        else begin
          m_run = 0; m_widx = 0;
        end
      end
    end
    m_load = issue;
    m_fs   = issue && (m_widx == 0);
    if (issue) begin
      m_widx = (m_widx + 1) % BANDS;
      if (q.size() > 0) begin
        m_po   = q.pop_front();
        m_last = m_po;
      end else begin
`ifdef PISO_FEEDER_REPEAT_EN
        m_po = m_last;
`else
        m_po = '0;
`endif
        m_ur = 1;
      end
    end
    if (m_acc) q.push_back(in_data);
  endtask

  task automatic check_all();
    chk("load",         32'(load),         32'(m_load));
    chk("frame_start",  32'(frame_start),  32'(m_fs));
    chk("parallel_out", 32'(parallel_out), 32'(m_po));
    chk("underrun",     32'(underrun),     32'(m_ur));
    chk("fifo_level",   32'(fifo_level),   32'(q.size()));
    chk("in_ready",     32'(in_ready),     32'(q.size() < DEPTH));
  endtask

  // One clock: model step, edge, then compare 1ns after the edge
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Run n cycles with the producer offering words per the current settings
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = (words_sent < feed_limit) && ($urandom_range(99) < vld_pct);
      in_data  = next_word;
      tick();
      if (m_acc) begin
        words_sent++;
        next_word = rnd_data ? WIDTH'($urandom) : next_word + 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_load"},  32'(load),         32'h0);
    chk({tag, "_fs"},    32'(frame_start),  32'h0);
    chk({tag, "_po"},    32'(parallel_out), 32'h0);
    chk({tag, "_ur"},    32'(underrun),     32'h0);
    chk({tag, "_level"}, 32'(fifo_level),   32'h0);
    chk({tag, "_ready"}, 32'(in_ready),     32'h1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_reset_values("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; in_data = '0; in_valid = 1'b0; enable = 1'b0;
    next_word = 12'h001; rnd_data = 0; words_sent = 0; feed_limit = 8; vld_pct = 100;
    model_reset();
    #1;
    do_reset();

    // Streaming with backpressure: 6 offers while idle, only DEPTH accepted
    run(6);
    chk("bp_level", 32'(fifo_level), 32'(DEPTH));
    chk("bp_ready", 32'(in_ready), 32'h0);
    enable = 1'b1;
    run(90);                       // eight slots drain words 1..8
    chk("stream_ur", 32'(underrun), 32'h0);
    chk("stream_last", 32'(parallel_out), 32'h008);
    run(30);                       // underrun slots, frame_start at BANDS+1 slot
    chk("underrun_set", 32'(underrun), 32'h1);

    // Enable drop at slot_cnt=5, then re-enable
    while (!m_load) run(1);
    run(5);
    enable = 1'b0;
    run(30);
    chk("drop_idle_load", 32'(load), 32'h0);
    enable = 1'b1;
    run(1);
    chk("reenable_fs", 32'(frame_start), 32'h1);

    // Reset mid-run with three words queued
    enable = 1'b0;
    do_reset();
    feed_limit = words_sent + 4;
    run(5);
    enable = 1'b1;
    run(4);
    chk("pre_reset_level", 32'(fifo_level), 32'h3);
    do_reset();
    run(3);

    // Randomized traffic: random data, valid density and enable toggling
    rnd_data   = 1;
    feed_limit = 32'h7fffffff;
    for (int ph = 0; ph < 12; ph++) begin
      vld_pct = (ph % 3 == 0) ? 40 : ((ph % 3 == 1) ? 9 : 3);
      enable  = ($urandom_range(3) != 0);
      run(200 + $urandom_range(60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
